// File: rtl/bmp_mem_arbiter_pkg.sv
// Shared constants and state encoding for the BMP memory arbiter.
//   ADDR_WIDTH_DEFAULT / BYTE_WIDTH_DEFAULT : byte address / data widths
//   N_REQ_DEFAULT                            : number of image engines
//   MAX_BURST_DEFAULT                        : owner accesses before forced hand-off
//   arb_state_e                              : IDLE / BUSY / DRAIN (2-bit encodings)
package bmp_mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 16;
  localparam int unsigned BYTE_WIDTH_DEFAULT = 8;
  localparam int unsigned N_REQ_DEFAULT      = 4;
  localparam int unsigned MAX_BURST_DEFAULT  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bmp_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first asserted request at or
// after i_ptr, wrapping around.
//   i_req   : request vector
//   i_ptr   : index of the highest-priority requester
//   o_pick  : one-hot selected requester (zero when no request)
//   o_idx   : index of the selected requester (zero when no request)
module bmp_mem_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;

  // Two linear passes (upper segment from the pointer, then the wrapped lower
  // segment) avoid a modulo index and keep the priority order explicit.
  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && (k >= 32'(i_ptr)) && i_req[k]) begin
        o_pick[k] = 1'b1;
        o_idx     = IDX_W'(k);
        w_found   = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && (k < 32'(i_ptr)) && i_req[k]) begin
        o_pick[k] = 1'b1;
        o_idx     = IDX_W'(k);
        w_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bmp_mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide ROM read port and RAM write port
// between N_REQ image engines, with a burst limit forcing hand-off when other
// engines are waiting.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req              : per-engine ownership request (level)
//   req_ren/req_wen  : per-engine ROM read / RAM write strobes
//   req_rom_addr     : flattened ROM addresses, engine k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ram_addr     : flattened RAM addresses
//   req_ram_in       : flattened RAM write data
//   ROM_out          : ROM read data, valid the cycle after ROM_ren
//   gnt              : registered one-hot grant
//   rd_valid         : one-hot tag saying which engine ROM_out belongs to
//   rd_data          : ROM_out pass-through
//   ROM_ren/ROM_addr : muxed ROM read port
//   RAM_wen/RAM_addr/RAM_in : muxed RAM write port
//   busy             : an owner exists
//   owner_id         : index of the current owner, 0 when idle
module bmp_mem_arbiter
  import bmp_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEFAULT,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              req_ren,
  input  logic [N_REQ-1:0]              req_wen,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_rom_addr,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_ram_addr,
  input  logic [N_REQ*BYTE_WIDTH-1:0]   req_ram_in,
  input  logic [BYTE_WIDTH-1:0]         ROM_out,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rd_valid,
  output logic [BYTE_WIDTH-1:0]         rd_data,
  output logic                          ROM_ren,
  output logic [ADDR_WIDTH-1:0]         ROM_addr,
  output logic                          RAM_wen,
  output logic [ADDR_WIDTH-1:0]         RAM_addr,
  output logic [BYTE_WIDTH-1:0]         RAM_in,
  output logic                          busy,
  output logic [2:0]                    owner_id
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_rd_valid;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_acc;

  logic [N_REQ-1:0] w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_ren, w_wen, w_owner_req, w_others, w_release;
  logic [ADDR_WIDTH-1:0] w_rom_addr, w_ram_addr;
  logic [BYTE_WIDTH-1:0] w_ram_in;

  bmp_mem_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  // r_gnt is one-hot in BUSY and zero elsewhere, so gating everything by it
  // both selects the owner and forces the ports to zero outside BUSY.
  always_comb begin
    w_rom_addr = '0;
    w_ram_addr = '0;
    w_ram_in   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_gnt[k]) begin
        w_rom_addr = req_rom_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_ram_addr = req_ram_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_ram_in   = req_ram_in[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign w_ren       = |(req_ren & r_gnt);
  assign w_wen       = |(req_wen & r_gnt);
  assign w_owner_req = |(req & r_gnt);
  assign w_others    = |(req & ~r_gnt);

  // Count including this cycle's access, so a tenure ends after exactly
  // MAX_BURST accesses while the final strobe is still accepted.
  assign w_cnt_acc = ((w_ren || w_wen) && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
  assign w_release = !w_owner_req || ((w_cnt_acc == CNT_MAX) && w_others);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_IDLE, ARB_DRAIN: begin
        if (|req) begin
          w_state_nxt = ARB_BUSY;
          w_gnt_nxt   = w_pick;
          w_owner_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        w_cnt_nxt = w_cnt_acc;
        if (w_release) begin
          w_state_nxt = ARB_DRAIN;
          w_gnt_nxt   = '0;
          w_owner_nxt = '0;
          w_ptr_nxt   = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rd_valid <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      // Tag with the owner at issue time; survives the release into DRAIN.
      r_rd_valid <= req_ren & r_gnt;
    end
  end

  assign gnt      = r_gnt;
  assign rd_valid = r_rd_valid;
  assign rd_data  = ROM_out;
  assign ROM_ren  = w_ren;
  assign ROM_addr = w_rom_addr;
  assign RAM_wen  = w_wen;
  assign RAM_addr = w_ram_addr;
  assign RAM_in   = w_ram_in;
  assign busy     = (r_state == ARB_BUSY);
  assign owner_id = 3'(r_owner);

endmodule

// File: tb/tb_bmp_mem_arbiter.sv
module tb_bmp_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 8;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_ren = '0;
  logic [N-1:0]    req_wen = '0;
  logic [N*AW-1:0] req_rom_addr = '0;
  logic [N*AW-1:0] req_ram_addr = '0;
  logic [N*BW-1:0] req_ram_in = '0;
  logic [BW-1:0]   ROM_out = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rd_valid;
  logic [BW-1:0]   rd_data;
  logic            ROM_ren;
  logic [AW-1:0]   ROM_addr;
  logic            RAM_wen;
  logic [AW-1:0]   RAM_addr;
  logic [BW-1:0]   RAM_in;
  logic            busy;
  logic [2:0]      owner_id;

  int n_checks = 0;
  int n_fail   = 0;

  bmp_mem_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .BYTE_WIDTH (BW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_ren      (req_ren),
    .req_wen      (req_wen),
    .req_rom_addr (req_rom_addr),
    .req_ram_addr (req_ram_addr),
    .req_ram_in   (req_ram_in),
    .ROM_out      (ROM_out),
    .gnt          (gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ROM_ren      (ROM_ren),
    .ROM_addr     (ROM_addr),
    .RAM_wen      (RAM_wen),
    .RAM_addr     (RAM_addr),
    .RAM_in       (RAM_in),
    .busy         (busy),
    .owner_id     (owner_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // ROM model: registered read, data the cycle after ROM_ren.
  always @(posedge clk) if (ROM_ren) ROM_out <= rom_val(ROM_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner = -1;   // -1: nobody owns the memories
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  int          m_tag   = -1;   // engine owed a read return this cycle
  logic [7:0]  m_byte  = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_tag = -1;
      end else if (m_owner >= 0) begin
        int  k;
        bit  others;
        k = m_owner;
        m_tag = -1;
        if (req_ren[k]) begin
          m_tag  = k;
          m_byte = rom_val(req_rom_addr[k*AW +: AW]);
        end
        if ((req_ren[k] || req_wen[k]) && m_cnt < MB) m_cnt++;
        others = 0;
        for (int j = 0; j < N; j++) if (j != k && req[j]) others = 1;
        if (!req[k] || (m_cnt == MB && others)) begin
          m_ptr   = (k + 1) % N;
          m_owner = -1;      // one empty (drain) cycle follows
        end
      end else begin
        m_tag = -1;
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (m_owner < 0 && req[j]) begin
            m_owner = j;
            m_cnt   = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      logic [N-1:0] e_gnt, e_rdv;
      @(negedge clk);
      e_gnt = '0;
      e_rdv = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
      if (m_tag >= 0) e_rdv[m_tag] = 1'b1;
      chk("m_gnt", gnt, e_gnt);
      chk("m_busy", busy, m_owner >= 0);
      chk("m_owner_id", owner_id, (m_owner >= 0) ? m_owner : 0);
      chk("m_rd_valid", rd_valid, e_rdv);
      chk("m_rd_data_pass", rd_data, ROM_out);
      if (m_tag >= 0) chk("m_rd_data", rd_data, m_byte);
      if (m_owner >= 0) begin
        chk("m_rom_ren", ROM_ren, req_ren[m_owner]);
        chk("m_rom_addr", ROM_addr, req_rom_addr[m_owner*AW +: AW]);
        chk("m_ram_wen", RAM_wen, req_wen[m_owner]);
        chk("m_ram_addr", RAM_addr, req_ram_addr[m_owner*AW +: AW]);
        chk("m_ram_in", RAM_in, req_ram_in[m_owner*BW +: BW]);
      end else begin
        chk("m_rom_ren_idle", ROM_ren, 0);
        chk("m_rom_addr_idle", ROM_addr, 0);
        chk("m_ram_wen_idle", RAM_wen, 0);
        chk("m_ram_addr_idle", RAM_addr, 0);
        chk("m_ram_in_idle", RAM_in, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; req_ren = '0; req_wen = '0;
    req_rom_addr = '0; req_ram_addr = '0; req_ram_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    at_neg();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rom_ren", ROM_ren, 0);
    chk("rst_ram_wen", RAM_wen, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] g [0:79];

  initial begin
    // 1: single grant and read return
    do_reset();
    req = 4'b0010;
    at_neg();
    chk("s1_idle_gnt", gnt, 0);
    cyc();
    req_rom_addr[1*AW +: AW] = 16'h0010;
    req_ren = 4'b0010;
    at_neg();
    chk("s1_gnt", gnt, 4'b0010);
    chk("s1_owner_id", owner_id, 1);
    chk("s1_busy", busy, 1);
    chk("s1_rom_ren", ROM_ren, 1);
    chk("s1_rom_addr", ROM_addr, 16'h0010);
    cyc();
    req_ren = '0;
    at_neg();
    chk("s1_rd_valid", rd_valid, 4'b0010);
    chk("s1_rd_data", rd_data, 8'hB5);
    cyc();
    req = '0;
    cyc();
    cyc();

    // 2: all engines requesting and strobing -> 16-access tenures in rotation
    do_reset();
    for (int k = 0; k < N; k++) req_rom_addr[k*AW +: AW] = 16'(16'h0100 * k + 16'h0003);
    req = 4'hF;
    req_ren = 4'hF;
    for (int i = 0; i < 72; i++) begin
      at_neg();
      g[i] = gnt;
      cyc();
    end
    for (int t = 0; t < 4; t++) begin
      int n;
      logic [N-1:0] exp_g;
      exp_g = '0;
      exp_g[t] = 1'b1;
      n = 0;
      for (int i = 0; i < 16; i++) if (g[1 + 17*t + i] == exp_g) n++;
      chk("s2_tenure_len", n, 16);
      chk("s2_drain_gap", g[17 + 17*t], 0);
    end
    chk("s2_first_idle", g[0], 0);
    chk("s2_wrap_to_0", g[69], 4'b0001);
    req = '0;
    req_ren = '0;
    cyc();
    cyc();

    // 3: lone requester keeps the grant past the burst limit
    req = 4'b0100;
    req_ren = 4'b0100;
    at_neg();
    chk("s3_idle", gnt, 0);
    cyc();
    for (int i = 0; i < 40; i++) begin
      at_neg();
      chk("s3_lone_gnt", gnt, 4'b0100);
      cyc();
    end
    req = '0;
    req_ren = '0;
    at_neg();
    chk("s3_still_gnt", gnt, 4'b0100);
    cyc();
    req = 4'hF;
    at_neg();
    chk("s3_drain", gnt, 0);
    cyc();
    at_neg();
    chk("s3_ptr3", gnt, 4'b1000);
    cyc();
    req = '0;
    cyc();
    cyc();

    // 4: owner reads and drops req in the same cycle
    do_reset();
    req = 4'b1001;
    cyc();
    req = 4'b1000;
    req_ren = 4'b0001;
    req_rom_addr[0 +: AW] = 16'h0033;
    at_neg();
    chk("s4_gnt0", gnt, 4'b0001);
    chk("s4_rom_addr", ROM_addr, 16'h0033);
    cyc();
    req_ren = '0;
    at_neg();
    chk("s4_drain_gnt", gnt, 0);
    chk("s4_drain_rdv", rd_valid, 4'b0001);
    chk("s4_drain_data", rd_data, 8'h96);
    cyc();
    at_neg();
    chk("s4_gnt3", gnt, 4'b1000);
    chk("s4_no_rdv3", rd_valid, 0);
    cyc();
    req = '0;
    cyc();

    // 5: non-owner write strobe is ignored
    do_reset();
    req = 4'b0001;
    req_wen = 4'b0011;
    req_ram_addr[0*AW +: AW] = 16'h0021;
    req_ram_addr[1*AW +: AW] = 16'h0055;
    req_ram_in[0*BW +: BW] = 8'h5A;
    req_ram_in[1*BW +: BW] = 8'h99;
    cyc();
    at_neg();
    chk("s5_wen", RAM_wen, 1);
    chk("s5_addr", RAM_addr, 16'h0021);
    chk("s5_in", RAM_in, 8'h5A);
    cyc();
    req_wen = 4'b0010;
    at_neg();
    chk("s5_nonowner_wen", RAM_wen, 0);
    cyc();
    req = '0;
    req_wen = '0;
    cyc();

    // 6: asynchronous reset mid-burst with a read outstanding
    do_reset();
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    req = 4'b0010;
    req_ren = 4'b0010;
    req_rom_addr[1*AW +: AW] = 16'h0020;
    cyc();
    cyc();
    cyc();
    chk("s6_pre_rdv", rd_valid, 4'b0010);
    chk("s6_pre_gnt", gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_gnt", gnt, 0);
    chk("s6_rst_rdv", rd_valid, 0);
    chk("s6_rst_rom_ren", ROM_ren, 0);
    chk("s6_rst_ram_wen", RAM_wen, 0);
    req = 4'b0011;
    req_ren = 4'b0011;
    cyc();
    rst_n = 1'b1;
    at_neg();
    chk("s6_idle_after_rst", gnt, 0);
    cyc();
    at_neg();
    chk("s6_restart_ptr0", gnt, 4'b0001);
    cyc();
    req = '0;
    req_ren = '0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
